rom_writer: RTL and testbench

Programming engine for bipolar fuse PROMs such as the 3601 / 556PT4 (256×4). It is the write-side counterpart of `rom_reader`. It accepts one address/word per `start` and pre-reads the location to check that the word is still programmable. It then blows fuses one bit at a time with timed program pulses, verifies each bit, retries failed bits, and ends with a full-word compare. It sits between the host control logic and the chip socket pin drivers, sharing address/data pins with `rom_reader` through the external mux.

---
 rtl/rom_pkg.sv | 29 ++
 rtl/rom_lowest_bit_select.sv | 14 +
 rtl/rom_writer.sv | 188 ++++++++++++++++++
 tb/tb_rom_writer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared operation codes for the fuse-PROM reader and writer engines.
// Both code sets live in one 4-bit space so a single status bus can tell them apart.
package rom_pkg;

  typedef enum logic [3:0] {
    WR_IDLE    = 4'd0,
    WR_PREREAD = 4'd1,
    WR_SETUP   = 4'd2,
    WR_PULSE   = 4'd3,
    WR_RECOVER = 4'd4,
    WR_VERIFY  = 4'd5,
    WR_FINAL   = 4'd6,
    WR_DONE    = 4'd7,
    WR_FAIL    = 4'd8
  } wr_state_t;

  typedef enum logic [3:0] {
    RD_ADDRESS = 4'd9,
    RD_ACCESS  = 4'd10,
    RD_CAPTURE = 4'd11
  } rd_state_t;

  function automatic int counter_width(int pulse_cycles, int settle_cycles);
    int longest;
    longest = (pulse_cycles > settle_cycles) ? pulse_cycles : settle_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/rom_lowest_bit_select.sv
// Picks the lowest set bit of a pending-fuse mask as a one-hot word.
// Purely combinational; any is high when the mask has at least one bit set.
module rom_lowest_bit_select #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] mask,
  output logic [DATA_WIDTH-1:0] onehot,
  output logic                  any
);

  assign onehot = mask & (~mask + DATA_WIDTH'(1));
  assign any    = |mask;

endmodule

// File: rtl/rom_writer.sv
// Bipolar fuse PROM programming engine: pre-read, per-bit timed pulses with
// verify and retry, then a full-word compare before reporting done or error.
module rom_writer
  import rom_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int PULSE_CYCLES  = 10,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [DATA_WIDTH-1:0]    data_line,
  output logic                     program_pulse,
  output logic                     chip_select_n,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [3:0]               operation
);

  localparam int CW = counter_width(PULSE_CYCLES, SETTLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRIES - 1);

  wr_state_t             state;
  logic [CW-1:0]         state_counter;
  logic [RW-1:0]         retry;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] pending;
  logic [DATA_WIDTH-1:0] cur_bit;
  logic [DATA_WIDTH-1:0] sel_mask;
  logic [DATA_WIDTH-1:0] sel_onehot;
  logic                  sel_any;

  // PREREAD selects from the freshly read word, VERIFY from pending minus the bit just proven.
  always_comb begin
    sel_mask = pending & ~cur_bit;
    if (state == WR_PREREAD) sel_mask = data_q & ~data_line_in;
  end

  rom_lowest_bit_select #(.DATA_WIDTH(DATA_WIDTH)) u_lowest (
    .mask   (sel_mask),
    .onehot (sel_onehot),
    .any    (sel_any)
  );

  assign operation = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WR_IDLE;
      state_counter <= '0;
      retry         <= '0;
      data_q        <= '0;
      pending       <= '0;
      cur_bit       <= '0;
      address_line  <= '0;
      data_line     <= '0;
      program_pulse <= 1'b0;
      chip_select_n <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_counter != '0 && state != WR_IDLE) state_counter <= state_counter - 1'b1;
      unique case (state)
        WR_IDLE: begin
          if (start) begin
            address_line  <= address;
            data_q        <= data;
            error         <= 1'b0;
            retry         <= '0;
            busy          <= 1'b1;
            chip_select_n <= 1'b0;
            state_counter <= SETTLE_LOAD;
            state         <= WR_PREREAD;
          end
        end
        WR_PREREAD: begin
          if (state_counter == '0) begin
            if ((data_line_in & ~data_q) != '0) begin
              chip_select_n <= 1'b1;
              error         <= 1'b1;
              state         <= WR_FAIL;
            end else begin
              pending       <= sel_mask;
              state_counter <= SETTLE_LOAD;
              if (sel_any) begin
                cur_bit       <= sel_onehot;
                data_line     <= sel_onehot;
                chip_select_n <= 1'b1;
                state         <= WR_SETUP;
              end else begin
                state <= WR_FINAL;
              end
            end
          end
        end
        WR_SETUP: begin
          if (state_counter == '0) begin
            program_pulse <= 1'b1;
            state_counter <= PULSE_LOAD;
            state         <= WR_PULSE;
          end
        end
        WR_PULSE: begin
          if (state_counter == '0) begin
            program_pulse <= 1'b0;
            state_counter <= SETTLE_LOAD;
            state         <= WR_RECOVER;
          end
        end
        WR_RECOVER: begin
          // data_line is still held for the first recovery cycle, then released.
          data_line <= '0;
          if (state_counter == '0) begin
            chip_select_n <= 1'b0;
            state_counter <= SETTLE_LOAD;
            state         <= WR_VERIFY;
          end
        end
        WR_VERIFY: begin
          if (state_counter == '0) begin
            if ((data_line_in & cur_bit) != '0) begin
              pending       <= sel_mask;
              retry         <= '0;
              state_counter <= SETTLE_LOAD;
              if (sel_any) begin
                cur_bit       <= sel_onehot;
                data_line     <= sel_onehot;
                chip_select_n <= 1'b1;
                state         <= WR_SETUP;
              end else begin
                state <= WR_FINAL;
              end
            end else if (retry == RETRY_LAST) begin
              chip_select_n <= 1'b1;
              error         <= 1'b1;
              state         <= WR_FAIL;
            end else begin
              retry         <= retry + 1'b1;
              data_line     <= cur_bit;
              chip_select_n <= 1'b1;
              state_counter <= SETTLE_LOAD;
              state         <= WR_SETUP;
            end
          end
        end
        WR_FINAL: begin
          if (state_counter == '0) begin
            chip_select_n <= 1'b1;
            if (data_line_in == data_q) begin
              done  <= 1'b1;
              state <= WR_DONE;
            end else begin
              error <= 1'b1;
              state <= WR_FAIL;
            end
          end
        end
        WR_DONE, WR_FAIL: begin
          busy          <= 1'b0;
          state_counter <= '0;
          state         <= WR_IDLE;
        end
        default: begin
          busy          <= 1'b0;
          chip_select_n <= 1'b1;
          program_pulse <= 1'b0;
          data_line     <= '0;
          state_counter <= '0;
          state         <= WR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_writer.sv
// Bench for rom_writer: behavioural fuse-chip model plus a per-write outcome
// model derived from the programming rules (pulse list, end cycle, result).
module tb_rom_writer;

  localparam int S  = 2;
  localparam int P  = 10;
  localparam int M  = 3;
  localparam int PB = 3 * S + P;
  localparam int LIMIT = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] address = '0;
  logic [3:0] data = '0;
  logic [3:0] data_line_in;
  logic [7:0] address_line;
  logic [3:0] data_line;
  logic       program_pulse;
  logic       chip_select_n;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] operation;

  int checks = 0;
  int failures = 0;

  logic [3:0] fuse [256];
  logic [3:0] stuck = 4'b0000;

  always #5 clk = ~clk;

  rom_writer #(
    .DATA_WIDTH(4), .ADDRESS_WIDTH(8), .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .MAX_RETRIES(M)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .address(address), .data(data),
    .data_line_in(data_line_in), .address_line(address_line), .data_line(data_line),
    .program_pulse(program_pulse), .chip_select_n(chip_select_n), .busy(busy),
    .done(done), .error(error), .operation(operation)
  );

  assign data_line_in = chip_select_n ? 4'b0000 : fuse[address_line];

  always @(posedge program_pulse) begin
    fuse[address_line] = fuse[address_line] | (data_line & ~stuck);
  end

  task automatic run_write(input logic [7:0] a, input logic [3:0] d, input int poke, input string name);
    logic [3:0] f0, pend, prev_dl;
    logic [3:0] exp_seq[$];
    logic [3:0] got_seq[$];
    logic       exp_ok, got_ok, prev_pp, seq_bad;
    int         exp_end, end_k, addr_bad, overlap, stab_bad, extra_done;
    f0 = fuse[a];
    exp_ok = 1'b1;
    if ((f0 & ~d) != 4'b0000) begin
      exp_ok = 1'b0;
    end else begin
      pend = d & ~f0;
      for (int i = 0; i < 4; i++) begin
        if (exp_ok && pend[i]) begin
          if (stuck[i]) begin
            for (int r = 0; r < M; r++) exp_seq.push_back(4'(1 << i));
            exp_ok = 1'b0;
          end else begin
            exp_seq.push_back(4'(1 << i));
          end
        end
      end
    end
    exp_end = exp_ok ? 1 + 2 * S + PB * exp_seq.size() : 1 + S + PB * exp_seq.size();

    @(negedge clk);
    address = a; data = d; start = 1'b1;
    @(posedge clk);
    end_k = 0; got_ok = 1'b0; addr_bad = 0; overlap = 0; stab_bad = 0; extra_done = 0;
    prev_pp = 1'b0; prev_dl = 4'b0000;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (poke != 0 && k == poke) begin start = 1'b1; address = ~a; data = ~d; end
      if (poke != 0 && k == poke + 1) start = 1'b0;
      if (address_line !== a) addr_bad++;
      if (program_pulse && !chip_select_n) overlap++;
      if (program_pulse && !prev_pp) begin
        got_seq.push_back(data_line);
        if (data_line !== prev_dl) stab_bad++;
      end
      if (!program_pulse && prev_pp && data_line !== prev_dl) stab_bad++;
      prev_pp = program_pulse; prev_dl = data_line;
      if (done || error) begin end_k = k; got_ok = done; break; end
    end

    checks++;
    if (end_k == 0) begin
      failures++; $display("FAIL %s timeout got=no_end required=end_by_%0d", name, LIMIT);
    end
    checks++;
    if (end_k != exp_end) begin
      failures++; $display("FAIL %s end_cycle got=%0d required=%0d", name, end_k, exp_end);
    end
    checks++;
    if (got_ok !== exp_ok) begin
      failures++; $display("FAIL %s outcome_done got=%0b required=%0b", name, got_ok, exp_ok);
    end
    seq_bad = (got_seq.size() != exp_seq.size());
    if (!seq_bad) for (int i = 0; i < exp_seq.size(); i++) if (got_seq[i] !== exp_seq[i]) seq_bad = 1'b1;
    checks++;
    if (seq_bad) begin
      failures++; $display("FAIL %s pulse_seq got_count=%0d required_count=%0d", name, got_seq.size(), exp_seq.size());
    end
    checks++;
    if (addr_bad != 0 || overlap != 0 || stab_bad != 0) begin
      failures++; $display("FAIL %s pin_rules addr_bad=%0d pulse_with_cs=%0d unstable=%0d required=0,0,0", name, addr_bad, overlap, stab_bad);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || operation !== 4'd0 || error !== !exp_ok) begin
      failures++; $display("FAIL %s after_end busy=%0b op=%0d error=%0b required=0,0,%0b", name, busy, operation, error, !exp_ok);
    end
    if (exp_ok) begin
      checks++;
      if (fuse[a] !== d) begin
        failures++; $display("FAIL %s chip_word got=%b required=%b", name, fuse[a], d);
      end
    end
    if (poke != 0) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done || busy) extra_done++;
      end
      checks++;
      if (extra_done != 0) begin
        failures++; $display("FAIL %s ignored_start extra_activity=%0d required=0", name, extra_done);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (address_line !== 8'h00 || data_line !== 4'h0 || program_pulse !== 1'b0 || chip_select_n !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || operation !== 4'd0) begin
      failures++;
      $display("FAIL %s reset_values got al=%h dl=%b pp=%b csn=%b busy=%b done=%b err=%b op=%0d required 00,0000,0,1,0,0,0,0",
               name, address_line, data_line, program_pulse, chip_select_n, busy, done, error, operation);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #23;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_plan_writes();
    stuck = 4'b0000;
    fuse[8'h3A] = 4'b0000;
    run_write(8'h3A, 4'b0101, 0, "blank_0101");
    fuse[8'h10] = 4'b0000;
    run_write(8'h10, 4'b0000, 0, "zero_word");
    fuse[8'h20] = 4'b0010;
    run_write(8'h20, 4'b0001, 0, "unprogrammable");
    fuse[8'h30] = 4'b0000;
    stuck = 4'b1000;
    run_write(8'h30, 4'b1000, 0, "stuck_bit3");
    stuck = 4'b0000;
    fuse[8'h31] = 4'b0000;
    run_write(8'h31, 4'b1111, 0, "clears_error_all_bits");
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [3:0] d;
    for (int n = 0; n < 12; n++) begin
      a = 8'($urandom_range(64, 255));
      d = 4'($urandom);
      fuse[a] = ($urandom_range(0, 2) != 0) ? (d & 4'($urandom)) : 4'($urandom);
      stuck = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      run_write(a, d, 0, $sformatf("random%0d", n));
    end
    stuck = 4'b0000;
  endtask

  task automatic test_reset_mid_pulse();
    int seen;
    fuse[8'h55] = 4'b0000;
    @(negedge clk);
    address = 8'h55; data = 4'b0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 60 && !program_pulse; k++) @(negedge clk);
    seen = program_pulse;
    checks++;
    if (seen !== 1) begin
      failures++; $display("FAIL reset_mid pulse_reached got=%0d required=1", seen);
    end
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (program_pulse !== 1'b0) begin
      failures++; $display("FAIL reset_mid pulse_drop got=%b required=0", program_pulse);
    end
    check_reset_values("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    fuse[8'h66] = 4'b0000;
    run_write(8'h66, 4'b0101, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    fuse[8'h47] = 4'b0000;
    run_write(8'h47, 4'b0110, 7, "start_while_busy");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fuse[i] = 4'b0000;
    test_reset();
    test_plan_writes();
    test_random();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
